// File: rtl/mul_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/busy/done handshake.
// The 4-bit add block is the only adder; it sums the partial-product high nibble with the multiplicand.

module add (
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    output logic [3:0] out,
    output logic       cout
);
    assign {cout, out} = {1'b0, num1} + {1'b0, num2};
endmodule

module mul_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic [3:0] add_out;
    logic       add_cout;
    logic [4:0] step_sum;

    add u_add (
        .num1 (hi_q),
        .num2 (mcand_q),
        .out  (add_out),
        .cout (add_cout)
    );

    // The carry is kept: it becomes bit 3 of the next high nibble after the shift.
    assign step_sum = lo_q[0] ? {add_cout, add_out} : {1'b0, hi_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 4'h0;
            hi_q      <= 4'h0;
            lo_q      <= 4'h0;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a;
                    hi_d    = 4'h0;
                    lo_d    = b;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {hi_d, lo_d} = {step_sum, lo_q[3:1]};
                cnt_d        = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = {step_sum, lo_q[3:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes a*b and the accept cycle; a monitor pops on every done.
module tb_mul_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] product;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    typedef struct {
        int expv;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("busy_during_done", int'(busy), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("product", int'(product), e.expv);
                chk("latency", cyc - e.acc, 4);
                chk("busy_cycles", busy_run, 4);
            end
        end
        busy_run = busy ? busy_run + 1 : 0;
    end

    task automatic drain();
        for (int i = 0; i < 20 && (sb.size() != 0 || busy || done); i++) @(negedge clk);
        @(negedge clk);
        chk("drain_outstanding", sb.size(), 0);
    endtask

    task automatic do_op(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        sb.push_back('{int'(x) * int'(y), cyc});
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom);
        drain();
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_product", int'(product), 0);
        repeat (10) @(negedge clk);

        do_op(4'd3, 4'd5);
        do_op(4'd15, 4'd15);
        do_op(4'd8, 4'd8);
        do_op(4'd0, 4'd9);
        do_op(4'd9, 4'd1);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_op(4'(x), 4'(y));

        for (int i = 0; i < 20; i++) do_op(4'($urandom), 4'($urandom));

        // start pulsed during RUN must be ignored
        @(negedge clk); a = 4'd7; b = 4'd6; start = 1'b1;
        @(negedge clk); sb.push_back('{42, cyc}); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 4'd2; b = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        drain();

        // back-to-back with start held high
        @(negedge clk); a = 4'd15; b = 4'd1; start = 1'b1;
        @(negedge clk); sb.push_back('{15, cyc});
        t = 0;
        while (!done && t < 10) begin @(negedge clk); t++; end
        chk("b2b_first_done", int'(done), 1);
        a = 4'd4; b = 4'd4;
        sb.push_back('{16, cyc + 1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_hold_product", int'(product), 15);
        end
        @(negedge clk);
        chk("b2b_second_done", int'(done), 1);
        start = 1'b0;
        drain();

        // reset mid-operation aborts with no done
        @(negedge clk); a = 4'd13; b = 4'd11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        repeat (8) @(negedge clk);
        chk("abort_product_idle", int'(product), 0);
        do_op(4'd2, 4'd3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
